// File: rtl/spad_sensor_emulator_pkg.sv
// Shared definitions for the SPAD sensor emulator: array geometry, FSM encoding
// and the pixel clamp helper.
package spad_sensor_emulator_pkg;

    localparam int SPAD_ROW_BITS   = 3;
    localparam int SPAD_COL_BITS   = 6;
    localparam int SPAD_LANES      = 4;
    localparam int SPAD_PIXEL_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_RESET_HELD  = 2'd1,
        ST_INTEGRATING = 2'd2,
        ST_LATCHED     = 2'd3
    } spad_state_e;

    // Clamp a widened pixel sum to full scale; any carry into the top two bits overflows.
    function automatic logic [SPAD_PIXEL_BITS-1:0] sat_pixel(
        input logic [SPAD_PIXEL_BITS+1:0] sum
    );
        return (|sum[SPAD_PIXEL_BITS+1:SPAD_PIXEL_BITS]) ? {SPAD_PIXEL_BITS{1'b1}}
                                                         : sum[SPAD_PIXEL_BITS-1:0];
    endfunction

endpackage

// File: rtl/spad_sensor_emulator_if.sv
// Controller <-> SPAD sensor bus: addressing/strobe from the controller,
// pixel lanes and frame status back from the sensor (or its emulator).
interface spad_sensor_emulator_if #(
    parameter int FRAME_ID_BITS = 16
) ();
    import spad_sensor_emulator_pkg::*;

    logic                       LatchSpad;
    logic                       ResetSpad;
    logic [SPAD_ROW_BITS-1:0]   RowSelect;
    logic [SPAD_COL_BITS-1:0]   ColSelect;
    logic                       RowGroup;
    logic [SPAD_PIXEL_BITS-1:0] PixelData0;
    logic [SPAD_PIXEL_BITS-1:0] PixelData1;
    logic [SPAD_PIXEL_BITS-1:0] PixelData2;
    logic [SPAD_PIXEL_BITS-1:0] PixelData3;
    logic [FRAME_ID_BITS-1:0]   FrameCount;
    logic                       Saturated;

    modport master (
        output LatchSpad, ResetSpad, RowSelect, ColSelect, RowGroup,
        input  PixelData0, PixelData1, PixelData2, PixelData3, FrameCount, Saturated
    );

    modport slave (
        input  LatchSpad, ResetSpad, RowSelect, ColSelect, RowGroup,
        output PixelData0, PixelData1, PixelData2, PixelData3, FrameCount, Saturated
    );

endinterface

// File: rtl/spad_emu_pixel_calc.sv
// One pixel lane: base + address pattern (+ optional noise), clamped at full scale.
module spad_emu_pixel_calc
    import spad_sensor_emulator_pkg::*;
(
    input  logic [SPAD_PIXEL_BITS-1:0] i_base,
    input  logic [SPAD_PIXEL_BITS-1:0] i_pat,
    input  logic [1:0]                 i_noise,
    output logic [SPAD_PIXEL_BITS-1:0] o_pix
);

    logic [SPAD_PIXEL_BITS+1:0] w_sum;

    assign w_sum = {2'b00, i_base} + {2'b00, i_pat} + {{SPAD_PIXEL_BITS{1'b0}}, i_noise};
    assign o_pix = sat_pixel(w_sum);

endmodule

// File: rtl/spad_sensor_emulator.sv
// Synthesizable SPAD imager stand-in: exposure-window FSM, frame capture and
// deterministic per-pixel counts. Define SPAD_EMU_NOISE_EN to add 0..3 LFSR noise per lane.
module spad_sensor_emulator
    import spad_sensor_emulator_pkg::*;
#(
    parameter int EXPOSURE_BITS  = 20,
    parameter int EXPOSURE_SHIFT = 8,
    parameter int FRAME_ID_BITS  = 16
`ifdef SPAD_EMU_NOISE_EN
    ,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    spad_sensor_emulator_if.slave bus
);

    localparam logic [EXPOSURE_BITS-1:0] EXP_MAX  = '1;
    localparam logic [EXPOSURE_BITS-1:0] EXP_ONE  = EXPOSURE_BITS'(1);
    localparam logic [EXPOSURE_BITS-1:0] BASE_LIM = EXPOSURE_BITS'(255);
    localparam logic [FRAME_ID_BITS-1:0] FRAME_ONE = FRAME_ID_BITS'(1);

    spad_state_e                r_state;
    logic [EXPOSURE_BITS-1:0]   r_exposure;
    logic [EXPOSURE_BITS-1:0]   r_cap_exp;
    logic [FRAME_ID_BITS-1:0]   r_frame_id;
    logic                       r_latch_d;
    logic                       r_saturated;
    logic [SPAD_PIXEL_BITS-1:0] r_pix_p1 [SPAD_LANES];

    logic                       w_latch_edge;
    logic                       w_capture;
    logic [EXPOSURE_BITS-1:0]   w_cap_next;
    logic [SPAD_PIXEL_BITS-1:0] w_base;
    logic [SPAD_PIXEL_BITS-1:0] w_pat_row;
    logic [1:0]                 w_noise [SPAD_LANES];
    logic [SPAD_PIXEL_BITS-1:0] w_pix   [SPAD_LANES];

    function automatic logic exp_over_full_scale(input logic [EXPOSURE_BITS-1:0] e);
        return (e >> EXPOSURE_SHIFT) > BASE_LIM;
    endfunction

    function automatic logic [SPAD_PIXEL_BITS-1:0] exp_to_base(input logic [EXPOSURE_BITS-1:0] e);
        logic [EXPOSURE_BITS-1:0] s;
        s = e >> EXPOSURE_SHIFT;
        return (s > BASE_LIM) ? {SPAD_PIXEL_BITS{1'b1}} : s[SPAD_PIXEL_BITS-1:0];
    endfunction

    // Latch edges in IDLE are dropped; in RESET_HELD the array holds no charge, so 0 is captured.
    assign w_latch_edge = bus.LatchSpad & ~r_latch_d;
    assign w_capture    = w_latch_edge && (r_state != ST_IDLE);
    assign w_cap_next   = (r_state == ST_RESET_HELD) ? '0 : r_exposure;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_exposure  <= '0;
            r_cap_exp   <= '0;
            r_frame_id  <= '0;
            r_latch_d   <= 1'b0;
            r_saturated <= 1'b0;
        end else begin
            r_latch_d <= bus.LatchSpad;
            if (w_capture) begin
                r_cap_exp   <= w_cap_next;
                r_frame_id  <= r_frame_id + FRAME_ONE;
                r_saturated <= exp_over_full_scale(w_cap_next);
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.ResetSpad) r_state <= ST_RESET_HELD;
                end
                ST_RESET_HELD: begin
                    r_exposure <= '0;
                    if (!bus.ResetSpad) r_state <= ST_INTEGRATING;
                end
                ST_INTEGRATING, ST_LATCHED: begin
                    if (bus.ResetSpad) begin
                        r_exposure <= '0;
                        r_state    <= ST_RESET_HELD;
                    end else begin
                        if (r_exposure != EXP_MAX) r_exposure <= r_exposure + EXP_ONE;
                        if (w_latch_edge) r_state <= ST_LATCHED;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPAD_EMU_NOISE_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_lfsr <= LFSR_SEED;
        else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
`endif

    // Stage p0: per-lane combinational pixel value from current address and captured frame.
    assign w_base    = exp_to_base(r_cap_exp);
    assign w_pat_row = 8'({bus.RowSelect, 3'b000}) + 8'(bus.ColSelect)
                     + {bus.RowGroup, 7'b0000000} + r_frame_id[7:0];

    for (genvar L = 0; L < SPAD_LANES; L++) begin : g_lane
`ifdef SPAD_EMU_NOISE_EN
        assign w_noise[L] = r_lfsr[2*L +: 2];
`else
        assign w_noise[L] = 2'b00;
`endif
        spad_emu_pixel_calc u_calc (
            .i_base  (w_base),
            .i_pat   (w_pat_row + 8'(L * 16)),
            .i_noise (w_noise[L]),
            .o_pix   (w_pix[L])
        );
    end

    // Stage p1: registered pixel lanes, one cycle after address sampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SPAD_LANES; i++) r_pix_p1[i] <= '0;
        end else begin
            for (int i = 0; i < SPAD_LANES; i++) r_pix_p1[i] <= w_pix[i];
        end
    end

    assign bus.PixelData0 = r_pix_p1[0];
    assign bus.PixelData1 = r_pix_p1[1];
    assign bus.PixelData2 = r_pix_p1[2];
    assign bus.PixelData3 = r_pix_p1[3];
    assign bus.FrameCount = r_frame_id;
    assign bus.Saturated  = r_saturated;

endmodule

// File: tb/tb_spad_sensor_emulator.sv
// Scoreboard bench for spad_sensor_emulator: default-parameter instance plus a
// short-exposure instance (11-bit counter, shift 2) so saturation is reachable quickly.
module tb_spad_sensor_emulator;
    import spad_sensor_emulator_pkg::*;

`ifdef SPAD_EMU_NOISE_EN
    localparam bit NOISE = 1'b1;
`else
    localparam bit NOISE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       tb_latch = 1'b0;
    logic       tb_rspad = 1'b0;
    logic [2:0] tb_row   = 3'd0;
    logic [5:0] tb_col   = 6'd0;
    logic       tb_grp   = 1'b0;

    spad_sensor_emulator_if bus_m ();
    spad_sensor_emulator_if bus_s ();

    assign bus_m.LatchSpad = tb_latch;
    assign bus_m.ResetSpad = tb_rspad;
    assign bus_m.RowSelect = tb_row;
    assign bus_m.ColSelect = tb_col;
    assign bus_m.RowGroup  = tb_grp;
    assign bus_s.LatchSpad = tb_latch;
    assign bus_s.ResetSpad = tb_rspad;
    assign bus_s.RowSelect = tb_row;
    assign bus_s.ColSelect = tb_col;
    assign bus_s.RowGroup  = tb_grp;

    spad_sensor_emulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m)
    );

    spad_sensor_emulator #(
        .EXPOSURE_BITS  (11),
        .EXPOSURE_SHIFT (2)
    ) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    typedef struct {
        int          due;
        string       name;
        bit          inst;
        bit          chk_pix;
        logic [7:0]  p0, p1, p2, p3;
        logic [15:0] fc;
        logic        sat;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    event ev_async;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int delay, input string name, input bit inst, input bit chk_pix,
                             input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                             input logic [7:0] p3, input logic [15:0] fc, input logic sat);
        exp_t e;
        e.due = (delay < 0) ? -1 : cyc + delay;
        e.name = name; e.inst = inst; e.chk_pix = chk_pix;
        e.p0 = p0; e.p1 = p1; e.p2 = p2; e.p3 = p3; e.fc = fc; e.sat = sat;
        sb_q.push_back(e);
    endtask

    task automatic check_field(input string nm, input logic [15:0] act, input logic [15:0] expv,
                               input bit tol);
        bit ok;
        n_checks++;
        ok = (act === expv);
        if (NOISE && tol) ok = (act >= expv) && ((act - expv) <= 16'd3);
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, expv);
    endtask

    task automatic compare(input exp_t e);
        logic [7:0]  a0, a1, a2, a3;
        logic [15:0] afc;
        logic        asat;
        if (e.inst) begin
            a0 = bus_s.PixelData0; a1 = bus_s.PixelData1; a2 = bus_s.PixelData2;
            a3 = bus_s.PixelData3; afc = bus_s.FrameCount; asat = bus_s.Saturated;
        end else begin
            a0 = bus_m.PixelData0; a1 = bus_m.PixelData1; a2 = bus_m.PixelData2;
            a3 = bus_m.PixelData3; afc = bus_m.FrameCount; asat = bus_m.Saturated;
        end
        check_field({e.name, ".FrameCount"}, afc, e.fc, 1'b0);
        check_field({e.name, ".Saturated"}, {15'd0, asat}, {15'd0, e.sat}, 1'b0);
        if (e.chk_pix) begin
            check_field({e.name, ".PixelData0"}, {8'd0, a0}, {8'd0, e.p0}, 1'b1);
            check_field({e.name, ".PixelData1"}, {8'd0, a1}, {8'd0, e.p1}, 1'b1);
            check_field({e.name, ".PixelData2"}, {8'd0, a2}, {8'd0, e.p2}, 1'b1);
            check_field({e.name, ".PixelData3"}, {8'd0, a3}, {8'd0, e.p3}, 1'b1);
        end
    endtask

    // Monitor: compares each queued expectation on its due cycle (or immediately for async ones).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or ev_async);
            #1;
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                if (e.due >= 0 && e.due < cyc) begin
                    n_checks++;
                    $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.due);
                end else begin
                    compare(e);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        expect_at(1, "reset_m", 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 1'b0);
        expect_at(1, "reset_s", 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 1'b0);
        @(negedge clk); reset = 1'b0;

        // Latch edge in IDLE is ignored; pattern at frame 0 still shows.
        @(negedge clk); tb_latch = 1'b1;
        expect_at(2, "idle_latch", 1'b0, 1'b1, 8'd0, 8'd16, 8'd32, 8'd48, 16'd0, 1'b0);
        @(negedge clk); tb_latch = 1'b0;

        // ResetSpad pulse, then 999 counts captured: base 3, frame 1.
        @(negedge clk); tb_rspad = 1'b1;
        @(negedge clk); tb_rspad = 1'b0;
        repeat (1000) @(negedge clk);
        tb_latch = 1'b1;
        expect_at(1, "frame1_fc", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd1, 1'b0);
        expect_at(2, "frame1", 1'b0, 1'b1, 8'd4, 8'd20, 8'd36, 8'd52, 16'd1, 1'b0);
        @(negedge clk); tb_latch = 1'b0;
        @(negedge clk); tb_grp = 1'b1; tb_row = 3'd2; tb_col = 6'd5;

        // Cumulative exposure ~2001: base 7, frame 2, pattern 151.
        repeat (999) @(negedge clk);
        tb_latch = 1'b1;
        expect_at(2, "frame2", 1'b0, 1'b1, 8'd158, 8'd174, 8'd190, 8'd206, 16'd2, 1'b0);
        @(negedge clk); tb_latch = 1'b0;
        @(negedge clk); tb_grp = 1'b1; tb_row = 3'd7; tb_col = 6'd63;

        // Past the small counter's range: it must hold at max, not wrap.
        repeat (2100) @(negedge clk);
        tb_latch = 1'b1;
        expect_at(2, "frame3_m", 1'b0, 1'b1, 8'd255, 8'd26, 8'd42, 8'd58, 16'd3, 1'b0);
        expect_at(2, "frame3_sat", 1'b1, 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 16'd3, 1'b1);
        @(negedge clk); tb_latch = 1'b0; tb_rspad = 1'b1;
        @(negedge clk); tb_rspad = 1'b0; tb_grp = 1'b0; tb_row = 3'd0; tb_col = 6'd0;

        // Latch and ResetSpad together after 512 counts: pre-clear exposure captured.
        repeat (513) @(negedge clk);
        tb_latch = 1'b1; tb_rspad = 1'b1;
        expect_at(2, "latch_rst_m", 1'b0, 1'b1, 8'd6, 8'd22, 8'd38, 8'd54, 16'd4, 1'b0);
        expect_at(2, "latch_rst_s", 1'b1, 1'b1, 8'd132, 8'd148, 8'd164, 8'd180, 16'd4, 1'b0);
        @(negedge clk); tb_latch = 1'b0;
        @(negedge clk);
        @(negedge clk); tb_latch = 1'b1;
        expect_at(2, "held_latch", 1'b0, 1'b1, 8'd5, 8'd21, 8'd37, 8'd53, 16'd5, 1'b0);
        @(negedge clk); tb_latch = 1'b0;
        @(negedge clk); tb_rspad = 1'b0;

        // Async reset mid-integration clears outputs before the next clock edge.
        repeat (50) @(negedge clk);
        #2;
        reset = 1'b1;
        expect_at(-1, "async_m", 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 1'b0);
        expect_at(-1, "async_s", 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 1'b0);
        ->ev_async;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
